// File: rtl/ddr_uart_tx_pkg.sv
// Shared constants for the display-data UART transmitter: FSM encoding,
// status-register bit positions and the idle line level.
package ddr_uart_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DSR_READY = 15;
  localparam int DSR_IE    = 14;
  localparam int DSR_OVR   = 1;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/ddr_uart_tx_baud_gen.sv
// Bit-period timer: one-cycle bit_tick_o every BAUD_DIV cycles, held at
// count 0 while clr_i is high so each frame starts on a fresh bit period.
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int              CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ddr_uart_tx.sv
// Memory-mapped 8N1 display transmitter: DSR holds READY/IE/OVR, a DDR
// write starts one frame on TXD, IRQ flags READY while interrupts are enabled.
module ddr_uart_tx
  import ddr_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD_DSR,
  input  logic        LD_DDR,
  input  logic [15:0] MDR,
  output logic [15:0] DSR,
  output logic [15:0] DDR,
  output logic        TXD,
  output logic        IRQ
);

  logic [1:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       ready_q, ready_d;
  logic       ie_q, ie_d;
  logic       ovr_q, ovr_d;
  logic       txd_q, txd_d;
  logic       ld_dsr_q, ld_ddr_q;
  logic       dsr_wr, ddr_wr, bit_tick;
  logic [2:0] nxt_bit;
  logic       unused_mdr;

  assign unused_mdr = ^{MDR[15], MDR[13:8]};

  // Strobes may be held for several cycles; only the rising edge is a write.
  assign dsr_wr  = LD_DSR & ~ld_dsr_q;
  assign ddr_wr  = LD_DDR & ~ld_ddr_q;
  assign nxt_bit = bit_q + 3'd1;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (state_q == ST_IDLE),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ready_d = ready_q;
    ie_d    = ie_q;
    ovr_d   = ovr_q;
    txd_d   = txd_q;

    if (dsr_wr) begin
      ie_d  = MDR[DSR_IE];
      ovr_d = 1'b0;
    end
    // Overrun wins over a simultaneous status-register clear.
    if (ddr_wr && !ready_q) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: if (ddr_wr && ready_q) begin
        state_d = ST_START;
        byte_d  = MDR[7:0];
        ready_d = 1'b0;
        txd_d   = 1'b0;
      end
      ST_START: if (bit_tick) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
        txd_d   = byte_q[0];
      end
      ST_DATA: if (bit_tick) begin
        bit_d = nxt_bit;
        if (bit_q == 3'd7) begin
          state_d = ST_STOP;
          txd_d   = LINE_IDLE;
        end else begin
          txd_d = byte_q[nxt_bit];
        end
      end
      default: if (bit_tick) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      byte_q   <= '0;
      ready_q  <= 1'b1;
      ie_q     <= 1'b0;
      ovr_q    <= 1'b0;
      txd_q    <= LINE_IDLE;
      ld_dsr_q <= 1'b0;
      ld_ddr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      ready_q  <= ready_d;
      ie_q     <= ie_d;
      ovr_q    <= ovr_d;
      txd_q    <= txd_d;
      ld_dsr_q <= LD_DSR;
      ld_ddr_q <= LD_DDR;
    end
  end

  always_comb begin
    DSR            = '0;
    DSR[DSR_READY] = ready_q;
    DSR[DSR_IE]    = ie_q;
    DSR[DSR_OVR]   = ovr_q;
  end

  assign DDR = {8'h00, byte_q};
  assign TXD = txd_q;
  assign IRQ = ready_q & ie_q;

endmodule

// File: tb/tb_ddr_uart_tx.sv
// Bench for ddr_uart_tx at BAUD_DIV=4: directed scenarios plus random strobe
// traffic, all checked against a frame-timer reference model.
module tb_ddr_uart_tx;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_dsr = 1'b0, ld_ddr = 1'b0;
  logic [15:0] mdr = 16'h0000;
  logic [15:0] dsr, ddr;
  logic        txd, irq;

  ddr_uart_tx #(.BAUD_DIV(BD)) dut (
    .CLK(clk), .RST(rst), .LD_DSR(ld_dsr), .LD_DDR(ld_ddr), .MDR(mdr),
    .DSR(dsr), .DDR(ddr), .TXD(txd), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- capture of what the DUT saw at each rising edge / reset ----
  int         rst_cnt = 0, clk_cnt = 0;
  logic       s_dsr = 1'b0, s_ddr = 1'b0;
  logic [15:0] s_mdr = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) rst_cnt <= rst_cnt + 1;
    else begin
      s_dsr   <= ld_dsr;
      s_ddr   <= ld_ddr;
      s_mdr   <= mdr;
      clk_cnt <= clk_cnt + 1;
    end
  end

  // ---- reference model: a frame is 10 bit-slots of BD cycles each ----
  bit       m_busy = 0, m_ie = 0, m_ovr = 0, m_pdsr = 0, m_pddr = 0;
  int       m_t = 0;
  logic [7:0] m_byte = 8'h00, m_last = 8'h00;
  int       seen_rst = 0, seen_clk = 0;
  bit       chk_en = 0;

  function automatic logic m_txd();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_t / BD;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  // frame monitor (negedge counter based)
  int  ncyc = 0, fall_cyc = 0, frame_len = -1, falls = 0;
  bit  prev_rdy = 1;

  initial forever begin
    bit dw, rw, rdy;
    @(negedge clk);
    if (rst_cnt != seen_rst) begin
      seen_rst = rst_cnt;
      m_busy = 0; m_ie = 0; m_ovr = 0; m_pdsr = 0; m_pddr = 0; m_t = 0; m_last = 8'h00;
    end
    if (clk_cnt != seen_clk) begin
      seen_clk = clk_cnt;
      dw = s_dsr && !m_pdsr;
      rw = s_ddr && !m_pddr;
      m_pdsr = s_dsr;
      m_pddr = s_ddr;
      rdy = !m_busy;
      if (m_busy) begin
        m_t++;
        if (m_t == FRAME) m_busy = 0;
      end
      if (dw) begin
        m_ie  = s_mdr[14];
        m_ovr = 0;
      end
      if (rw) begin
        if (rdy) begin
          m_busy = 1; m_t = 0; m_byte = s_mdr[7:0]; m_last = s_mdr[7:0];
        end else m_ovr = 1;
      end
    end
    if (chk_en && !rst) begin
      chk("m_txd", txd, m_txd());
      chk("m_dsr", dsr, {!m_busy, m_ie, 12'h000, m_ovr, 1'b0});
      chk("m_ddr", ddr, {8'h00, m_last});
      chk("m_irq", irq, (!m_busy) && m_ie);
      if (prev_rdy && !dsr[15]) begin falls++; fall_cyc = ncyc; end
      if (!prev_rdy && dsr[15]) frame_len = ncyc - fall_cyc;
      prev_rdy = dsr[15];
    end
    ncyc++;
  end

  // ---- stimulus helpers ----
  task automatic wr_ddr(input logic [15:0] d, input int hold);
    @(negedge clk);
    mdr = d; ld_ddr = 1'b1;
    repeat (hold) @(negedge clk);
    ld_ddr = 1'b0;
  endtask

  task automatic wr_dsr(input logic [15:0] d);
    @(negedge clk);
    mdr = d; ld_dsr = 1'b1;
    @(negedge clk);
    ld_dsr = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!dsr[15]) begin
      if (n >= 200) begin
        chk({tag, "_timeout"}, 0, 1);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_frame(input string tag, input logic [15:0] d);
    logic exp_b;
    wr_ddr(d, 1);
    chk({tag, "_ddr"}, ddr, {8'h00, d[7:0]});
    chk({tag, "_rdy0"}, dsr[15], 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_b = 1'b0;
      else if (i == 9) exp_b = 1'b1;
      else             exp_b = d[i-1];
      chk($sformatf("%s_bit%0d", tag, i), txd, exp_b);
      repeat (BD) @(negedge clk);
    end
    chk({tag, "_rdy1"}, dsr[15], 1'b1);
    @(negedge clk);
    chk({tag, "_len"}, frame_len, FRAME);
  endtask

  initial begin
    int f0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dsr", dsr, 16'h8000);
    chk("rst_ddr", ddr, 16'h0000);
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // basic frame, alternating bits
    send_frame("f55", 16'h1255);

    // interrupt enable and IRQ across a frame
    wr_dsr(16'h4000);
    chk("ie_dsr", dsr, 16'hC000);
    chk("ie_irq", irq, 1'b1);
    wr_ddr(16'h0033, 1);
    repeat (20) @(negedge clk);
    chk("irq_mid", irq, 1'b0);
    wait_ready("irqf");
    chk("irq_end", irq, 1'b1);
    @(negedge clk);
    chk("irq_len", frame_len, FRAME);

    // overrun mid-frame, then cleared by a status write
    wr_ddr(16'h1255, 1);
    repeat (10) @(negedge clk);
    wr_ddr(16'h00AA, 1);
    chk("ovr_ddr", ddr, 16'h0055);
    chk("ovr_set", dsr[1], 1'b1);
    wait_ready("ovrf");
    wr_dsr(16'h0000);
    chk("ovr_clr", dsr[1], 1'b0);

    // long strobe counts once
    f0 = falls;
    wr_ddr(16'h003C, 6);
    wait_ready("hold");
    repeat (8) @(negedge clk);
    chk("hold_frames", falls - f0, 1);
    chk("hold_ovr", dsr[1], 1'b0);

    // asynchronous reset in DATA bit 3
    wr_ddr(16'h00F0, 1);
    repeat (17) @(negedge clk);
    chk("pre_rst_txd", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_dsr", dsr, 16'h8000);
    chk("arst_ddr", ddr, 16'h0000);
    #1 rst = 1'b0;
    @(negedge clk);
    send_frame("f81", 16'h0081);

    // random strobe traffic, model-checked every cycle
    repeat (3000) begin
      @(negedge clk);
      ld_ddr = ld_ddr ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
      ld_dsr = ld_dsr ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 59) == 0);
      mdr    = 16'($urandom);
    end
    @(negedge clk);
    ld_ddr = 1'b0;
    ld_dsr = 1'b0;
    wait_ready("rnd");
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_uart_tx.md
DDR_UART_TX -- requirements
Module: ddr_uart_tx

Interface
REQ-001 The module SHALL have one parameter: BAUD_DIV, default 434, the number of clock cycles per serial bit (50 MHz / 115200).
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset; asynchronous and active-high, the only reset.
REQ-004 LD_DSR  input  1  write strobe for the display status register, from the address-control decode.
REQ-005 LD_DDR  input  1  write strobe for the display data register, from the address-control decode.
REQ-006 MDR  input  16  write data bus.
REQ-007 DSR  output  16  status register to the read mux: bit15 READY, bit14 IE, bit1 OVR, all other bits 0.
REQ-008 DDR  output  16  last accepted data: {8'h00, byte}.
REQ-009 TXD  output  1  serial 8N1 line, idle high.
REQ-010 IRQ  output  1  interrupt request, equal to READY & IE.

Function
REQ-011 A write SHALL be accepted only on a strobe's rising edge (strobe high this cycle, low the previous cycle), so a multi-cycle strobe counts as one write.
REQ-012 DDR write with READY=1: latch MDR[7:0] into DDR, clear READY on the next edge, enter START; TXD goes 0 in the same cycle READY clears.
REQ-013 DDR write with READY=0: DDR and the frame in flight stay unchanged, OVR sets (sticky).
REQ-014 DSR write: IE <= MDR[14], OVR cleared; READY is read-only and unaffected.
REQ-015 FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on an accepted DDR write.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8*BAUD_DIV cycles.
  - STOP -> IDLE after BAUD_DIV cycles.
REQ-016 The DATA state SHALL send the byte LSB first, each bit held exactly BAUD_DIV cycles; TXD=1 in STOP and IDLE.
REQ-017 READY SHALL set on the edge that leaves STOP, so a frame lasts exactly 10*BAUD_DIV cycles from READY falling to READY rising.
REQ-018 A DDR write that arrives in the same cycle STOP completes SHALL be treated as READY=0 (dropped, OVR set).
REQ-019 Simultaneous DSR and DDR writes SHALL both take effect.
  - OVR set by the DDR write takes priority over OVR clear by the DSR write.
REQ-020 The baud counter SHALL be ceil(log2(BAUD_DIV)) bits wide and restart at 0 on every state entry.
  - The bit counter is 3 bits and wraps after bit 7 into STOP.
REQ-021 IRQ SHALL be combinational from the registered READY and IE.

Reset
REQ-022 On RST high, the following SHALL take effect immediately, regardless of clock:
  - state = IDLE
  - TXD = 1
  - READY = 1, IE = 0, OVR = 0
  - DDR = 16'h0000
  - counters = 0
  - strobe-edge history = 0
REQ-023 An asserted RST SHALL abort a frame in flight with no partial stop bit; the line returns high the same instant.

Structure
REQ-024 A shared package SHALL hold:
  - the state enumeration
  - DSR bit indices (READY=15, IE=14, OVR=1)
  - the IDLE line level constant
REQ-025 One sub-module, uart_baud_gen, SHALL produce a single-cycle bit_tick every BAUD_DIV cycles, clear-on-restart.

Verification
REQ-026 Bench SHALL use BAUD_DIV=4 and cover these scenarios:
  - Reset -> DSR=16'h8000, DDR=0, TXD=1, IRQ=0.
  - DDR write MDR=16'h1255 -> DDR=16'h0055; READY=0 next cycle; TXD = 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit; READY=1 exactly 40 cycles after falling.
  - DSR write 16'h4000 while idle -> DSR=16'hC000, IRQ=1; then DDR write -> IRQ=0 for the whole frame, back to 1 at frame end.
  - Second DDR write 16'h00AA mid-frame -> DDR stays 16'h0055, TXD stream unchanged, DSR[1]=1; later DSR write 16'h0000 -> DSR[1]=0.
  - LD_DDR held high 6 cycles -> exactly one frame sent, OVR stays 0.
  - RST pulse in DATA state at bit 3 -> TXD=1 and READY=1 asynchronously; next DDR write 16'h0081 sends a clean frame.
